// File: rtl/capture_ctrl.sv
// Capture controller for a logic-analyser trace RAM: decimated sampling into a
// circular buffer, pre-trigger fill, arm, post-trigger count and done hand-off.
module capture_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strt_cap,
  input  logic       triggered,
  input  logic [8:0] trig_pos,
  input  logic [3:0] decimator,
  input  logic       clr_cap_done,
  output logic       we,
  output logic       cap_en,
  output logic [8:0] cap_addr,
  output logic [8:0] trace_end,
  output logic       armed,
  output logic       cap_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [8:0]  trig_pos_r, trig_pos_s;
  logic [3:0]  dec_r, dec_s;
  logic [15:0] dec_cnt_r, dec_cnt_s;
  logic [9:0]  wr_cnt_r, wr_cnt_s;
  logic [9:0]  post_cnt_r, post_cnt_s;
  logic [8:0]  cap_addr_r, cap_addr_s;
  logic [8:0]  trace_end_r, trace_end_s;
  logic        we_r, we_s;
  logic        armed_r, armed_s;
  logic        cap_done_r, cap_done_s;

  logic        active_s;
  logic        smpl_en_s;
  logic [15:0] dec_limit_s;
  logic [9:0]  wr_cnt_inc_s;
  logic [9:0]  post_cnt_inc_s;
  logic [9:0]  fill_thresh_s;
  logic [8:0]  last_addr_s;

  assign cap_en    = smpl_en_s;
  assign cap_addr  = cap_addr_r;
  assign trace_end = trace_end_r;
  assign we        = we_r;
  assign armed     = armed_r;
  assign cap_done  = cap_done_r;

  // Next-state, datapath and registered-output decode
  always_comb begin
    dec_limit_s    = (16'd1 << dec_r) - 16'd1;
    active_s       = (state_r == FILL) || (state_r == ARMED) || (state_r == POST);
    smpl_en_s      = active_s && (dec_cnt_r == dec_limit_s);
    wr_cnt_inc_s   = (wr_cnt_r == 10'd512) ? 10'd512 : (wr_cnt_r + 10'd1);
    post_cnt_inc_s = post_cnt_r + 10'd1;
    fill_thresh_s  = 10'd512 - {1'b0, trig_pos_r};
    // a write in this very cycle is the most recent one; otherwise the previous address
    last_addr_s    = smpl_en_s ? cap_addr_r : (cap_addr_r - 9'd1);

    state_s     = state_r;
    trig_pos_s  = trig_pos_r;
    dec_s       = dec_r;
    wr_cnt_s    = wr_cnt_r;
    post_cnt_s  = post_cnt_r;
    trace_end_s = trace_end_r;
    cap_addr_s  = smpl_en_s ? (cap_addr_r + 9'd1) : cap_addr_r;
    if (active_s) begin
      dec_cnt_s = smpl_en_s ? 16'd0 : (dec_cnt_r + 16'd1);
    end else begin
      dec_cnt_s = dec_cnt_r;
    end

    case (state_r)
      IDLE: begin
        if (strt_cap) begin
          trig_pos_s = trig_pos;
          dec_s      = decimator;
          wr_cnt_s   = 10'd0;
          post_cnt_s = 10'd0;
          dec_cnt_s  = 16'd0;
          state_s    = FILL;
        end else begin
          state_s    = IDLE;
        end
      end
      FILL: begin
        if (smpl_en_s) begin
          wr_cnt_s = wr_cnt_inc_s;
          if (wr_cnt_inc_s >= fill_thresh_s) begin
            state_s = ARMED;
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = FILL;
        end
      end
      ARMED: begin
        if (triggered) begin
          if (trig_pos_r == 9'd0) begin
            trace_end_s = last_addr_s;
            state_s     = DONE;
          end else begin
            post_cnt_s  = 10'd0;
            state_s     = POST;
          end
        end else begin
          state_s = ARMED;
        end
      end
      POST: begin
        if (smpl_en_s) begin
          post_cnt_s = post_cnt_inc_s;
          if (post_cnt_inc_s == {1'b0, trig_pos_r}) begin
            trace_end_s = cap_addr_r;
            state_s     = DONE;
          end else begin
            state_s     = POST;
          end
        end else begin
          state_s = POST;
        end
      end
      DONE: begin
        if (clr_cap_done) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    we_s       = (state_s == FILL) || (state_s == ARMED) || (state_s == POST);
    armed_s    = (state_s == ARMED);
    cap_done_s = (state_s == DONE);
  end

  // State, counters, addresses and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      trig_pos_r  <= 9'd0;
      dec_r       <= 4'd0;
      dec_cnt_r   <= 16'd0;
      wr_cnt_r    <= 10'd0;
      post_cnt_r  <= 10'd0;
      cap_addr_r  <= 9'd0;
      trace_end_r <= 9'd0;
      we_r        <= 1'b0;
      armed_r     <= 1'b0;
      cap_done_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      trig_pos_r  <= trig_pos_s;
      dec_r       <= dec_s;
      dec_cnt_r   <= dec_cnt_s;
      wr_cnt_r    <= wr_cnt_s;
      post_cnt_r  <= post_cnt_s;
      cap_addr_r  <= cap_addr_s;
      trace_end_r <= trace_end_s;
      we_r        <= we_s;
      armed_r     <= armed_s;
      cap_done_r  <= cap_done_s;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: a table of complete captures with
// hand-computed write counts/addresses, plus reset and hand-off corner cases.
module tb_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       strt_cap, triggered, clr_cap_done;
  logic [8:0] trig_pos;
  logic [3:0] decimator;
  logic       we, cap_en, armed, cap_done;
  logic [8:0] cap_addr, trace_end;

  capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .strt_cap(strt_cap), .triggered(triggered),
    .trig_pos(trig_pos), .decimator(decimator), .clr_cap_done(clr_cap_done),
    .we(we), .cap_en(cap_en), .cap_addr(cap_addr), .trace_end(trace_end),
    .armed(armed), .cap_done(cap_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dec; int tp; int j; bit ftrig;
    int exp_fill; int exp_arm; int exp_post; int exp_arm_clks;
    int exp_start; int exp_caddr; int exp_tend;
  } vec_t;

  vec_t vecs[6];
  int nchk = 0;
  int nerr = 0;

  // observation state, written only by the monitor
  int ncyc = 0, fill_cnt = 0, arm_cnt = 0, post_cnt = 0, gap_err = 0, addr_err = 0, any_en = 0;
  int we_rise = 0, arm_rise = 0, done_rise = 0, trig_cyc = 0;
  int first_en = 0, first_addr = 0, last_en = 0, last_addr = 0, mon_id = 0;
  bit prev_we = 1'b0, prev_armed = 1'b0, prev_done = 1'b0, post_phase = 1'b0;
  // written only by the stimulus
  int cap_id = 0;
  int cur_period = 1;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (we && !prev_we) we_rise = ncyc;
    if (armed && !prev_armed) arm_rise = ncyc;
    if (cap_done && !prev_done) done_rise = ncyc;
    if (cap_en) begin
      any_en = any_en + 1;
      if (mon_id != cap_id) begin
        mon_id = cap_id;
        first_en = ncyc;
        first_addr = int'(cap_addr);
      end else begin
        if (ncyc - last_en != cur_period) gap_err = gap_err + 1;
        if (int'(cap_addr) != (last_addr + 1) % 512) addr_err = addr_err + 1;
      end
      if (armed) arm_cnt = arm_cnt + 1;
      else if (post_phase) post_cnt = post_cnt + 1;
      else fill_cnt = fill_cnt + 1;
      last_en = ncyc;
      last_addr = int'(cap_addr);
    end
    if (triggered && armed) begin
      trig_cyc = ncyc;
      post_phase = 1'b1;
    end
    if (!we) post_phase = 1'b0;
    prev_we = we;
    prev_armed = armed;
    prev_done = cap_done;
  end

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_armed(input string name);
    int t = 0;
    while (!armed && t < 40000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!armed) timeout(name);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int s_fill, s_arm, s_post, s_gap, s_adr, t;
    string tag;
    tag = $sformatf("v%0d", idx);
    cap_id++;
    cur_period = 1 << v.dec;
    s_fill = fill_cnt; s_arm = arm_cnt; s_post = post_cnt; s_gap = gap_err; s_adr = addr_err;
    @(posedge clk); #1;
    trig_pos = 9'(v.tp); decimator = 4'(v.dec); strt_cap = 1'b1;
    @(posedge clk); #1;
    strt_cap = 1'b0;
    // latched settings must not follow later input changes
    trig_pos = 9'd511 - 9'(v.tp); decimator = 4'd15 - 4'(v.dec);
    if (v.ftrig) begin
      repeat (2) @(posedge clk);
      #1 triggered = 1'b1;
      @(posedge clk); #1 triggered = 1'b0;
    end
    wait_armed({tag, "_armed"});
    repeat (v.j - 1) @(posedge clk);
    #1 triggered = 1'b1;
    @(posedge clk); #1;
    triggered = 1'b0;
    strt_cap = 1'b1;
    @(posedge clk); #1 strt_cap = 1'b0;
    t = 0;
    while (!cap_done && t < 40000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cap_done) timeout({tag, "_done"});
    @(negedge clk); #1;
    check({tag, "_fill_writes"}, fill_cnt - s_fill, v.exp_fill);
    check({tag, "_armed_writes"}, arm_cnt - s_arm, v.exp_arm);
    check({tag, "_post_writes"}, post_cnt - s_post, v.exp_post);
    check({tag, "_cap_en_spacing"}, gap_err - s_gap, 0);
    check({tag, "_addr_continuity"}, addr_err - s_adr, 0);
    check({tag, "_clks_to_armed"}, arm_rise - we_rise, v.exp_arm_clks);
    check({tag, "_first_cap_en"}, first_en - we_rise, cur_period - 1);
    check({tag, "_first_addr"}, first_addr, v.exp_start);
    check({tag, "_trace_end"}, int'(trace_end), v.exp_tend);
    check({tag, "_cap_addr"}, int'(cap_addr), v.exp_caddr);
    check({tag, "_done_we"}, int'(we), 0);
    check({tag, "_done_armed"}, int'(armed), 0);
    if (v.tp == 0) check({tag, "_done_latency"}, done_rise - trig_cyc, 1);
    // clear together with a start: only the clear may take effect
    @(posedge clk); #1;
    clr_cap_done = 1'b1; strt_cap = 1'b1;
    @(posedge clk); #1;
    clr_cap_done = 1'b0; strt_cap = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check({tag, "_idle_we"}, int'(we), 0);
    check({tag, "_idle_cap_done"}, int'(cap_done), 0);
  endtask

  initial begin
    int en_snap;
    rst_n = 1'b0; strt_cap = 1'b0; triggered = 1'b0; clr_cap_done = 1'b0;
    trig_pos = 9'd0; decimator = 4'd0;

    //          dec  tp   j  ft  fill arm post armclk start caddr tend
    vecs[0] = '{0, 100, 500, 1'b0, 412, 500, 100,  412,   0, 500, 499};
    vecs[1] = '{0,  20,   1, 1'b1, 492,   1,  20,  492, 500, 501, 500};
    vecs[2] = '{3, 256,   5, 1'b0, 256,   0, 256, 2048, 501, 501, 500};
    vecs[3] = '{0,   0,   3, 1'b0, 512,   3,   0,  512, 501, 504, 503};
    vecs[4] = '{1, 511,   4, 1'b0,   1,   2, 511,    2, 504, 506, 505};
    vecs[5] = '{2,  10,   6, 1'b0, 502,   1,  10, 2008,   0,   1,   0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_we", int'(we), 0);
    check("rst_cap_en", int'(cap_en), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_cap_done", int'(cap_done), 0);
    check("rst_cap_addr", int'(cap_addr), 0);
    check("rst_trace_end", int'(trace_end), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_no_start_we", int'(we), 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // abort a capture mid-POST with an asynchronous reset
    cap_id++;
    cur_period = 1;
    @(posedge clk); #1;
    trig_pos = 9'd100; decimator = 4'd0; strt_cap = 1'b1;
    @(posedge clk); #1 strt_cap = 1'b0;
    wait_armed("abort_armed");
    triggered = 1'b1;
    @(posedge clk); #1 triggered = 1'b0;
    repeat (10) @(posedge clk);
    #3 check("abort_pre_cap_en", int'(cap_en), 1);
    rst_n = 1'b0;
    #1;
    check("abort_we", int'(we), 0);
    check("abort_cap_en", int'(cap_en), 0);
    check("abort_armed_out", int'(armed), 0);
    check("abort_cap_done", int'(cap_done), 0);
    check("abort_cap_addr", int'(cap_addr), 0);
    check("abort_trace_end", int'(trace_end), 0);
    en_snap = any_en;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("abort_no_writes", any_en - en_snap, 0);
    check("abort_stays_idle", int'(we), 0);

    run_vec(vecs[5], 5);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
